// File: rtl/config_unit_multi_pkg.sv
// ---------------------------------------------------------------------------
// config_unit_pkg
// Shared types and constants for the multi-channel configuration unit.
//   state_t  : session state machine encoding (IDLE, AUTH, OPEN, LOCK)
//   FIELD_P  : field-select value for the P threshold
//   FIELD_Q  : field-select value for the Q threshold
// ---------------------------------------------------------------------------
package config_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AUTH = 2'd1,
        OPEN = 2'd2,
        LOCK = 2'd3
    } state_t;

    localparam logic FIELD_P = 1'b0;
    localparam logic FIELD_Q = 1'b1;

endpackage

// File: rtl/config_unit_multi_reg_bank.sv
// ---------------------------------------------------------------------------
// config_reg_bank
// Per-channel P/Q threshold storage. One write per cycle; the field bit picks
// P or Q inside the addressed channel. Only reset clears the contents.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   i_we         : write enable
//   i_ch         : channel index (indices >= NUM_CH are never written)
//   i_field      : FIELD_P or FIELD_Q
//   i_value      : threshold value
//   o_dataP      : packed P thresholds, channel i at [i*VAL_W +: VAL_W]
//   o_dataQ      : packed Q thresholds, same packing
// ---------------------------------------------------------------------------
module config_reg_bank
    import config_unit_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int VAL_W  = 7
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      i_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_ch,
    input  logic                                      i_field,
    input  logic [VAL_W-1:0]                          i_value,
    output logic [NUM_CH*VAL_W-1:0]                   o_dataP,
    output logic [NUM_CH*VAL_W-1:0]                   o_dataQ
);

    logic [NUM_CH-1:0][VAL_W-1:0] r_p;
    logic [NUM_CH-1:0][VAL_W-1:0] r_q;

    // Storage array: the loop compares the index against each channel so an
    // out-of-range index simply matches nothing rather than indexing past
    // the end of the array.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_p <= '0;
            r_q <= '0;
        end else if (i_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(i_ch) == i) begin
                    if (i_field == FIELD_Q) begin
                        r_q[i] <= i_value;
                    end else begin
                        r_p[i] <= i_value;
                    end
                end
            end
        end
    end

    assign o_dataP = r_p;
    assign o_dataQ = r_q;

endmodule

// File: rtl/config_unit_multi.sv
// ---------------------------------------------------------------------------
// config_unit_multi
// Multi-channel configuration unit. A session is opened with request, the
// caller authenticates with the key code and a confirm pulse, and each later
// confirm writes a P or Q threshold into the channel given by ch_sel.
// Repeated wrong keys lock the unit out for LOCK_CYCLES cycles; a key change
// while open drops the session back to authentication.
// Ports:
//   clock, reset   : clock and asynchronous active-high reset
//   request        : session enable (level)
//   confirm        : action strobe, only its rising edge acts
//   key            : expected key code
//   input_data     : key attempt in AUTH, {field, value} in OPEN
//   ch_sel         : target channel for writes
//   data_p, data_q : packed P/Q thresholds per channel
//   auth_ok        : session open
//   error          : one-cycle pulse on wrong key or invalid channel
//   locked         : lockout in progress
//   ack            : one-cycle pulse on each accepted write
// ---------------------------------------------------------------------------
module config_unit_multi
    import config_unit_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int KEY_W       = 8,
    parameter int NUM_CH      = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           request,
    input  logic                                           confirm,
    input  logic [KEY_W-1:0]                               key,
    input  logic [DATA_W-1:0]                              input_data,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    output logic [NUM_CH*(DATA_W-1)-1:0]                   data_p,
    output logic [NUM_CH*(DATA_W-1)-1:0]                   data_q,
    output logic                                           auth_ok,
    output logic                                           error,
    output logic                                           locked,
    output logic                                           ack
);

    localparam int VAL_W  = DATA_W - 1;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    state_t             r_state;
    logic [FAIL_W-1:0]  r_failCnt;
    logic [LOCK_W-1:0]  r_lockCnt;
    logic [KEY_W-1:0]   r_keyAtOpen;
    logic               r_confirmQ;
    logic               r_error;
    logic               r_ack;

    state_t             w_stateNext;
    logic [FAIL_W-1:0]  w_failNext;
    logic [LOCK_W-1:0]  w_lockNext;
    logic [KEY_W-1:0]   w_keyAtOpenNext;
    logic               w_errorNext;
    logic               w_ackNext;
    logic               w_we;

    logic               w_confRise;
    logic               w_keyMatch;
    logic               w_chValid;
    logic               w_keyChanged;

    assign w_confRise   = confirm & ~r_confirmQ;
    assign w_keyMatch   = (input_data[KEY_W-1:0] == key);
    assign w_chValid    = (32'(ch_sel) < NUM_CH);
    // The key captured on entry to OPEN is the reference; any later change of
    // the system key invalidates the current session.
    assign w_keyChanged = (key != r_keyAtOpen);

    // State, counters and the registered error/ack pulses. The confirm edge
    // register runs in every state so a confirm held across a state change
    // never looks like a fresh rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_failCnt   <= '0;
            r_lockCnt   <= '0;
            r_keyAtOpen <= '0;
            r_confirmQ  <= 1'b0;
            r_error     <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_failCnt   <= w_failNext;
            r_lockCnt   <= w_lockNext;
            r_keyAtOpen <= w_keyAtOpenNext;
            r_confirmQ  <= confirm;
            r_error     <= w_errorNext;
            r_ack       <= w_ackNext;
        end
    end

    // Next-state logic. In OPEN a request drop beats a key change, which in
    // turn beats a write, so error and ack can never fire together.
    always_comb begin
        w_stateNext     = r_state;
        w_failNext      = r_failCnt;
        w_lockNext      = r_lockCnt;
        w_keyAtOpenNext = r_keyAtOpen;
        w_errorNext     = 1'b0;
        w_ackNext       = 1'b0;
        w_we            = 1'b0;

        case (r_state)
            IDLE: begin
                if (request) begin
                    w_stateNext = AUTH;
                end
            end

            AUTH: begin
                if (!request) begin
                    w_stateNext = IDLE;
                end else if (w_confRise) begin
                    if (w_keyMatch) begin
                        w_stateNext     = OPEN;
                        w_failNext      = '0;
                        w_keyAtOpenNext = key;
                    end else begin
                        w_errorNext = 1'b1;
                        w_failNext  = r_failCnt + FAIL_W'(1);
                        if (r_failCnt == FAIL_W'(MAX_FAIL - 1)) begin
                            w_stateNext = LOCK;
                            w_lockNext  = LOCK_W'(LOCK_CYCLES - 1);
                        end
                    end
                end
            end

            OPEN: begin
                if (!request) begin
                    w_stateNext = IDLE;
                end else if (w_keyChanged) begin
                    w_stateNext = AUTH;
                end else if (w_confRise) begin
                    if (w_chValid) begin
                        w_we      = 1'b1;
                        w_ackNext = 1'b1;
                    end else begin
                        w_errorNext = 1'b1;
                    end
                end
            end

            LOCK: begin
                if (r_lockCnt == '0) begin
                    w_stateNext = IDLE;
                    w_failNext  = '0;
                end else begin
                    w_lockNext = r_lockCnt - LOCK_W'(1);
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    config_reg_bank #(
        .NUM_CH (NUM_CH),
        .VAL_W  (VAL_W)
    ) u_regBank (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_we),
        .i_ch    (ch_sel),
        .i_field (input_data[DATA_W-1]),
        .i_value (input_data[VAL_W-1:0]),
        .o_dataP (data_p),
        .o_dataQ (data_q)
    );

    assign auth_ok = (r_state == OPEN);
    assign locked  = (r_state == LOCK);
    assign error   = r_error;
    assign ack     = r_ack;

endmodule

// File: tb/tb_config_unit_multi.sv
// ---------------------------------------------------------------------------
// tb_config_unit_multi
// Directed bench for config_unit_multi. A four-channel instance is the main
// device; a three-channel instance shares all inputs so ch_sel = 3 can be
// seen as valid on one and invalid on the other.
// ---------------------------------------------------------------------------
module tb_config_unit_multi;

    logic        clock;
    logic        reset;
    logic        request;
    logic        confirm;
    logic [7:0]  key;
    logic [7:0]  input_data;
    logic [1:0]  ch_sel;

    logic [27:0] data_p;
    logic [27:0] data_q;
    logic        auth_ok;
    logic        error;
    logic        locked;
    logic        ack;

    logic [20:0] data_p3;
    logic [20:0] data_q3;
    logic        auth_ok3;
    logic        error3;
    logic        locked3;
    logic        ack3;

    int nCompared   = 0;
    int nMismatched = 0;

    config_unit_multi #(
        .DATA_W(8), .KEY_W(8), .NUM_CH(4), .MAX_FAIL(3), .LOCK_CYCLES(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .request    (request),
        .confirm    (confirm),
        .key        (key),
        .input_data (input_data),
        .ch_sel     (ch_sel),
        .data_p     (data_p),
        .data_q     (data_q),
        .auth_ok    (auth_ok),
        .error      (error),
        .locked     (locked),
        .ack        (ack)
    );

    config_unit_multi #(
        .DATA_W(8), .KEY_W(8), .NUM_CH(3), .MAX_FAIL(3), .LOCK_CYCLES(16)
    ) dut3 (
        .clock      (clock),
        .reset      (reset),
        .request    (request),
        .confirm    (confirm),
        .key        (key),
        .input_data (input_data),
        .ch_sel     (ch_sel),
        .data_p     (data_p3),
        .data_q     (data_q3),
        .auth_ok    (auth_ok3),
        .error      (error3),
        .locked     (locked3),
        .ack        (ack3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and land just after it, away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        request    = 1'b0;
        confirm    = 1'b0;
        key        = 8'h06;
        input_data = 8'h00;
        ch_sel     = 2'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        nCompared++;
        if ({auth_ok, error, locked, ack} !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {auth_ok, error, locked, ack});
        end
        nCompared++;
        if ({data_p, data_q} !== 56'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_data: got %h/%h expected 0/0", data_p, data_q);
        end
    endtask

    task automatic test_wrong_key();
        request = 1'b1;
        tick();
        input_data = 8'h04;
        confirm    = 1'b1;
        tick();
        nCompared++;
        if ({error, auth_ok, locked, ack} !== 4'b1000) begin
            nMismatched++;
            $display("[TB] FAIL wrong_key_pulse: got err/auth/lock/ack %b expected 1000", {error, auth_ok, locked, ack});
        end
        confirm = 1'b0;
        tick();
        nCompared++;
        if ({error, auth_ok, locked, ack} !== 4'b0000 || {data_p, data_q} !== 56'h0) begin
            nMismatched++;
            $display("[TB] FAIL wrong_key_after: got flags %b data %h/%h expected 0000 0/0",
                     {error, auth_ok, locked, ack}, data_p, data_q);
        end
    endtask

    task automatic test_auth_write();
        input_data = 8'h06;
        confirm    = 1'b1;
        tick();
        nCompared++;
        if ({auth_ok, error} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL auth_open: got auth/err %b expected 10", {auth_ok, error});
        end
        confirm = 1'b0;
        tick();
        ch_sel     = 2'd2;
        input_data = 8'h85;
        confirm    = 1'b1;
        tick();
        nCompared++;
        if (ack !== 1'b1 || error !== 1'b0 || data_q[14 +: 7] !== 7'h05 || data_p[14 +: 7] !== 7'h00) begin
            nMismatched++;
            $display("[TB] FAIL write_q_ch2: got ack %b err %b q2 %h p2 %h expected 1 0 05 00",
                     ack, error, data_q[14 +: 7], data_p[14 +: 7]);
        end
        confirm = 1'b0;
        tick();
        nCompared++;
        if (ack !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL ack_one_cycle: got %b expected 0", ack);
        end
        input_data = 8'h13;
        confirm    = 1'b1;
        tick();
        nCompared++;
        if (ack !== 1'b1 || data_p[14 +: 7] !== 7'h13 || data_q[14 +: 7] !== 7'h05) begin
            nMismatched++;
            $display("[TB] FAIL write_p_ch2: got ack %b p2 %h q2 %h expected 1 13 05",
                     ack, data_p[14 +: 7], data_q[14 +: 7]);
        end
        confirm = 1'b0;
        tick();
    endtask

    task automatic test_held_confirm();
        int acks = 0;
        ch_sel     = 2'd1;
        input_data = 8'h2A;
        confirm    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack) acks++;
            input_data = 8'h11;
        end
        nCompared++;
        if (acks !== 1) begin
            nMismatched++;
            $display("[TB] FAIL held_confirm_acks: got %0d expected 1", acks);
        end
        nCompared++;
        if (data_p[7 +: 7] !== 7'h2A) begin
            nMismatched++;
            $display("[TB] FAIL held_confirm_data: got p1 %h expected 2a", data_p[7 +: 7]);
        end
        confirm = 1'b0;
        tick();
    endtask

    task automatic test_invalid_channel();
        ch_sel     = 2'd3;
        input_data = 8'h0C;
        confirm    = 1'b1;
        tick();
        nCompared++;
        if ({ack, error} !== 2'b10 || data_p[21 +: 7] !== 7'h0C) begin
            nMismatched++;
            $display("[TB] FAIL ch3_valid_4ch: got ack/err %b p3 %h expected 10 0c", {ack, error}, data_p[21 +: 7]);
        end
        nCompared++;
        if ({ack3, error3, auth_ok3} !== 3'b011 || data_p3 !== {7'h13, 7'h2A, 7'h00} || data_q3 !== {7'h05, 7'h00, 7'h00}) begin
            nMismatched++;
            $display("[TB] FAIL ch3_invalid_3ch: got ack/err/auth %b p %h q %h expected 011 %h %h",
                     {ack3, error3, auth_ok3}, data_p3, data_q3, {7'h13, 7'h2A, 7'h00}, {7'h05, 7'h00, 7'h00});
        end
        confirm = 1'b0;
        tick();
        nCompared++;
        if (error3 !== 1'b0 || auth_ok3 !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL ch3_error_one_cycle: got err %b auth %b expected 0 1", error3, auth_ok3);
        end
    endtask

    task automatic test_key_change();
        key = 8'h86;
        tick();
        nCompared++;
        if (auth_ok !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL key_change_drop: got auth %b expected 0", auth_ok);
        end
        input_data = 8'h06;
        confirm    = 1'b1;
        tick();
        nCompared++;
        if ({error, auth_ok} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL old_key_rejected: got err/auth %b expected 10", {error, auth_ok});
        end
        confirm = 1'b0;
        tick();
        input_data = 8'h86;
        confirm    = 1'b1;
        tick();
        nCompared++;
        if (auth_ok !== 1'b1 || error !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL new_key_open: got auth %b err %b expected 1 0", auth_ok, error);
        end
        confirm = 1'b0;
        tick();
        nCompared++;
        if (data_p[14 +: 7] !== 7'h13 || data_q[14 +: 7] !== 7'h05 || data_p[7 +: 7] !== 7'h2A || data_p[21 +: 7] !== 7'h0C) begin
            nMismatched++;
            $display("[TB] FAIL data_persist: got p %h q %h expected p2 13 q2 05 p1 2a p3 0c", data_p, data_q);
        end
        // Key change and confirm rise together: the write must be dropped.
        key        = 8'h06;
        ch_sel     = 2'd0;
        input_data = 8'h7F;
        confirm    = 1'b1;
        tick();
        nCompared++;
        if ({auth_ok, ack, error} !== 3'b000 || data_p[6:0] !== 7'h00) begin
            nMismatched++;
            $display("[TB] FAIL key_change_beats_write: got auth/ack/err %b p0 %h expected 000 00",
                     {auth_ok, ack, error}, data_p[6:0]);
        end
        confirm = 1'b0;
        tick();
    endtask

    task automatic test_lockout();
        int  lockCycles = 0;
        bit  done       = 1'b0;
        bit  sawOpen    = 1'b0;
        bit  sawError   = 1'b0;
        input_data = 8'h55;
        for (int n = 0; n < 3; n++) begin
            confirm = 1'b1;
            tick();
            nCompared++;
            if (error !== 1'b1 || locked !== (n == 2)) begin
                nMismatched++;
                $display("[TB] FAIL lock_wrong_%0d: got err %b locked %b expected 1 %b", n, error, locked, (n == 2));
            end
            if (n < 2) begin
                confirm = 1'b0;
                tick();
            end
        end
        if (locked) lockCycles = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            request    = i[1];
            confirm    = i[0];
            input_data = 8'h06;
            tick();
            if (locked) lockCycles++;
            else done = 1'b1;
            if (auth_ok) sawOpen = 1'b1;
            if (error || ack) sawError = 1'b1;
        end
        nCompared++;
        if (lockCycles !== 16) begin
            nMismatched++;
            $display("[TB] FAIL lock_length: got %0d cycles expected 16", lockCycles);
        end
        nCompared++;
        if (sawOpen || sawError) begin
            nMismatched++;
            $display("[TB] FAIL lock_ignores_inputs: got open %b err/ack %b expected 0 0", sawOpen, sawError);
        end
        request = 1'b1;
        confirm = 1'b0;
        tick();
        // Two wrong keys after the lockout must not lock again.
        input_data = 8'h55;
        for (int n = 0; n < 2; n++) begin
            confirm = 1'b1;
            tick();
            confirm = 1'b0;
            tick();
        end
        nCompared++;
        if (locked !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL fail_count_cleared: got locked %b expected 0", locked);
        end
        input_data = 8'h06;
        confirm    = 1'b1;
        tick();
        nCompared++;
        if (auth_ok !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reopen_after_lock: got auth %b expected 1", auth_ok);
        end
        confirm = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        // Mid-OPEN, between clock edges.
        #2 reset = 1'b1;
        #1;
        nCompared++;
        if ({auth_ok, error, locked, ack} !== 4'b0000 || {data_p, data_q} !== 56'h0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset_open: got flags %b data %h/%h expected 0000 0/0",
                     {auth_ok, error, locked, ack}, data_p, data_q);
        end
        #2 reset = 1'b0;
        tick();
        tick();
        input_data = 8'h55;
        for (int n = 0; n < 3; n++) begin
            confirm = 1'b1;
            tick();
            confirm = 1'b0;
            tick();
        end
        tick();
        nCompared++;
        if (locked !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reach_lock: got locked %b expected 1", locked);
        end
        // Mid-LOCK, between clock edges.
        #2 reset = 1'b1;
        #1;
        nCompared++;
        if ({auth_ok, error, locked, ack} !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL async_reset_lock: got flags %b expected 0000", {auth_ok, error, locked, ack});
        end
        request = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();
        nCompared++;
        if ({auth_ok, locked} !== 2'b00 || {data_p, data_q} !== 56'h0) begin
            nMismatched++;
            $display("[TB] FAIL idle_after_reset: got auth/locked %b data %h/%h expected 00 0/0",
                     {auth_ok, locked}, data_p, data_q);
        end
    endtask

    initial begin
        test_reset();
        test_wrong_key();
        test_auth_write();
        test_held_confirm();
        test_invalid_channel();
        test_key_change();
        test_lockout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/config_unit_multi.md
Name: config_unit_multi

Overview:
- Parametrised, multi-channel successor to the single-channel healthcare configuration unit.
- A caller opens a session with `request` and authenticates by presenting the key code on `input_data` with a `confirm` pulse.
- Once authenticated, each further `confirm` writes a P or Q threshold into the channel selected by `ch_sel`.
- Adds failure counting with a timed lockout, per-channel storage, key-change relock and a write acknowledge.

Parameters:
- DATA_W, 8: width of `input_data`. The MSB is the field select; the low DATA_W-1 bits are the threshold value.
- KEY_W, 8: width of `key`. Must be <= DATA_W.
- NUM_CH, 4: number of sensor channels, each holding one P and one Q register.
- MAX_FAIL, 3: consecutive failed authentications that trigger lockout (>= 1).
- LOCK_CYCLES, 16: length of the lockout in clock cycles (>= 1).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- request  in  1  session enable, level-sensitive.
- confirm  in  1  action strobe; only its rising edge (0->1 across consecutive samples) acts.
- key  in  KEY_W  expected key code, held stable by the system.
- input_data  in  DATA_W  key attempt in AUTH; {field, value} in OPEN.
- ch_sel  in  $clog2(NUM_CH)  target channel for writes; a value >= NUM_CH is invalid.
- data_p  out  NUM_CH*(DATA_W-1)  P thresholds; channel i occupies bits [i*(DATA_W-1) +: DATA_W-1].
- data_q  out  NUM_CH*(DATA_W-1)  Q thresholds, same packing as `data_p`.
- auth_ok  out  1  high while in OPEN.
- error  out  1  one-cycle pulse on a wrong key or an invalid `ch_sel`.
- locked  out  1  high while in LOCK.
- ack  out  1  one-cycle pulse on each accepted write.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; fail_cnt = 0; lock_cnt = 0; confirm edge register = 0.
  - All `data_p`/`data_q` registers = 0.
  - `auth_ok`, `error`, `locked`, `ack` = 0.
  - Reset mid-session, including mid-lockout, returns to IDLE with all of the above cleared.
- Edge detection: `conf_rise` = `confirm` & ~`confirm_q`. A `confirm` held high produces exactly one action.
- IDLE:
  - `request` = 1 -> AUTH on the next edge.
  - `confirm` is ignored in IDLE.
- AUTH:
  - `request` = 0 -> IDLE (disable); `fail_cnt` is kept.
  - `conf_rise` with `input_data[KEY_W-1:0]` == `key` -> OPEN; `fail_cnt` cleared.
  - `conf_rise` with a mismatch -> `error` pulses in the following cycle and `fail_cnt` increments.
    - If the new count == MAX_FAIL: -> LOCK, `lock_cnt` loaded with LOCK_CYCLES-1.
    - Otherwise: remain in AUTH.
- OPEN:
  - `request` = 0 -> IDLE.
  - `key` differs from its value sampled on entry to OPEN -> AUTH; any `conf_rise` in that same cycle is ignored.
  - `conf_rise` with `ch_sel` < NUM_CH:
    - Writes `input_data[DATA_W-2:0]` into channel `ch_sel`, field P if `input_data[DATA_W-1]` = 0, else Q.
    - `ack` pulses. Outputs update one cycle after the `conf_rise` sample.
  - `conf_rise` with `ch_sel` >= NUM_CH -> no write, `error` pulses.
  - Priority within one cycle: `request` drop > key change > write.
- LOCK:
  - `request` and `confirm` are ignored.
  - `lock_cnt` decrements each cycle; at 0 -> IDLE with `fail_cnt` = 0.
  - `locked` is high for exactly LOCK_CYCLES cycles.
- Output registers:
  - Stored thresholds persist across sessions, key changes and lockout.
  - Only reset clears them.
- Outputs: all outputs are registered (no combinational input-to-output paths). `error` and `ack` are never high in the same cycle.

Decomposition:
- Package `config_unit_pkg`:
  - State enum: IDLE, AUTH, OPEN, LOCK (2-bit).
  - Field constants: FIELD_P = 0, FIELD_Q = 1.
- Sub-module `config_reg_bank`, parametrised by NUM_CH and VAL_W = DATA_W-1:
  - Inputs: write enable, channel index, field bit, value.
  - Output: packed P/Q vectors, with asynchronous reset.
- The FSM, `fail_cnt`/`lock_cnt` counters and the confirm edge detector stay in the top module.

Test Plan (defaults NUM_CH=4, DATA_W=8, KEY_W=8, MAX_FAIL=3, LOCK_CYCLES=16):
- Wrong key: key = 8'h06, request = 1, confirm rise with input_data = 8'h04 -> `error` pulses once, state stays AUTH, `auth_ok` = 0, all outputs 0.
- Authenticate and write: input_data = 8'h06 with confirm rise -> `auth_ok` = 1. Then ch_sel = 2, input_data = 8'h85, confirm rise -> `data_q` ch2 = 7'h05, `ack` pulses. Then input_data = 8'h13 -> `data_p` ch2 = 7'h13.
- Held confirm and invalid channel:
  - `confirm` held high for 5 cycles in OPEN -> exactly one write and one `ack`.
  - ch_sel = 3 is valid; at NUM_CH=3, ch_sel = 3 -> `error`, no write.
- Key change mid-session: in OPEN, key changes 8'h06 -> 8'h86 -> `auth_ok` drops next cycle (AUTH).
  - input_data = 8'h06 -> `error`.
  - input_data = 8'h86 -> OPEN. Previously stored values are unchanged.
- Lockout: three wrong keys -> `locked` high for 16 cycles, and a correct key presented during lockout has no effect. Then IDLE; a correct key after re-request opens the session with `fail_cnt` back at 0.
- Async reset: assert reset mid-LOCK and mid-OPEN, between clock edges -> all outputs 0 immediately, state IDLE, stored thresholds cleared.
